axi_sram_slave: RTL and testbench
=================================

# axi_sram_slave

AXI3 slave-side responder backing a word-addressed on-chip SRAM array. It accepts read and write bursts from the single merged master port that the cache-side 2-to-1 arbiter produces, so it is the memory end of that bus in cache/SoC simulation and on-board bring-up. Read and write channels run independently. Each channel has one outstanding transaction, with INCR and FIXED burst support and byte-strobed writes.

## Interface
- DEPTH_LOG2, 12: log2 of array depth in 32-bit words. Address index is addr[DEPTH_LOG2+1:2]; upper bits are ignored, so accesses alias.
- INIT_FILE, "": optional $readmemh image; empty means the array is uninitialised.
- aclk  in  1  clock; all logic is on the rising edge.
- aresetn  in  1  asynchronous active-low reset.
- arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot  in  4/32/4/3/2/2/4/3  AR payload. arlock, arcache and arprot are ignored.
- arvalid in 1; arready out 1.
- rid out 4; rdata out 32; rresp out 2; rlast out 1; rvalid out 1; rready in 1.
- awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot  in  4/32/4/3/2/2/4/3  AW payload. awlock, awcache and awprot are ignored.
- awvalid in 1; awready out 1.
- wid in 4 (ignored); wdata in 32; wstrb in 4; wlast in 1; wvalid in 1; wready out 1.
- bid out 4; bresp out 2; bvalid out 1; bready in 1.

## Operation
**Read FSM: R_IDLE -> R_BURST -> R_IDLE**
- R_IDLE: arready=1.
- On arvalid&&arready:
  - latch arid, araddr, arlen and arburst;
  - clear the beat counter;
  - move to R_BURST.
- R_BURST:
  - rvalid=1; rdata is the registered array word at the current index.
  - rid is the latched id; rresp=2'b00.
  - rlast=(beat==arlen).
- On rvalid&&rready:
  - beat increments.
  - Address advances by 4 for INCR. WRAP (2'b10) is treated as INCR. FIXED holds the address.
  - The next word loads into rdata.
  - If rlast was set, return to R_IDLE.
- rdata, rid, rresp and rlast hold stable while rvalid&&!rready.

**Write FSM: W_IDLE -> W_DATA -> W_RESP -> W_IDLE**
- W_IDLE: awready=1.
- On handshake: latch awid, awaddr, awlen and awburst; clear the beat counter and the error flag.
- W_DATA: wready=1. On each wvalid&&wready:
  - write the bytes of wdata whose wstrb bit is set;
  - advance the address (same rule as read);
  - increment beat;
  - if wlast != (beat==awlen), set the error flag.
- The burst terminates on the beat where beat==awlen, regardless of wlast. Then go to W_RESP.
- W_RESP:
  - bvalid=1 and bid is the latched id.
  - bresp=2'b10 (SLVERR) if the error flag is set, else 2'b00.
  - Return to W_IDLE on bready.
- arsize/awsize are not checked; every beat is a full 32-bit word lane.

## Timing
- Reset (aresetn=0): both FSMs go to idle.
  - arready, awready, wready, rvalid and bvalid are 0.
  - rlast=0; rresp=bresp=2'b00; rid=bid=4'h0; rdata=32'h0.
  - The array is not cleared.
- arready and awready are registered. They first read 1 in the cycle after aresetn rises, and never assert while in reset.
- Read latency: with AR handshake at edge T, rvalid=1 from cycle T+1 carrying word[araddr].
  - Back-to-back beats run at 1 beat/cycle with rready held.
  - After the last beat handshakes at edge L, arready=1 from L+1. The next rvalid is at L+2 at the earliest.
- Write latency: with AW handshake at edge T, wready=1 from T+1, 1 beat/cycle.
  - With the last W beat at edge L, bvalid=1 from L+1.
  - awready=1 again the cycle after the B handshake.
- W beats that arrive before the AW handshake are not accepted; wready stays 0.
- Same-cycle read and write of one word: a read beat loaded at edge E returns the pre-write value of a write committed at E. Words loaded at later edges see the new data.
- Address wrap: an INCR burst at the top index wraps to index 0.
- Reset mid-burst: the transaction is dropped and all outputs take their reset values immediately (asynchronously). Array contents written before reset persist.

## Test plan
- Single read: preload word 0x40 = 32'hDEADBEEF; arid=4'h2, araddr=0x100, arlen=0 -> rvalid at T+1, rdata=DEADBEEF, rid=2, rlast=1, rresp=0.
- Burst write then read: awaddr=0x200, awlen=7, wdata=i+1, wstrb=4'hF, wlast on beat 7 -> bvalid at L+1 with bresp=0. Then araddr=0x200, arlen=7 -> rdata 1..8 with rlast only on the 8th beat, including random rready stalls where the data is held stable.
- Strobes: word 0x300 = 32'h11223344; write 32'hAABBCCDD with wstrb=4'b0101 -> read returns 32'h11BB33DD.
- wlast error: awlen=3 with wlast asserted on beat 1 -> 4 beats accepted, bresp=2'b10, bid=awid.
- FIXED burst of 4 writes values 1..4 to 0x80 -> word 0x80 reads 4. INCR read at index 2^DEPTH_LOG2-1 with arlen=1 -> second beat returns index 0.
- Concurrency and reset: an overlapping 8-beat read and 8-beat write complete independently. aresetn pulsed low mid-read -> rvalid and arready are 0 during reset, arready=1 the cycle after release, and previously written data is intact.

Source files
------------

// File: rtl/axi_sram_slave_if.sv
// AXI3 bus bundle between the merged cache-side master and the SRAM responder.
// Carries the five channels; clock and reset stay outside as plain ports.
interface axi_sram_slave_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;

    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI3 slave backed by a word-addressed SRAM; independent read and write FSMs,
// one outstanding transaction per channel, INCR/FIXED bursts, byte strobes.
module axi_sram_slave #(
    parameter int DEPTH_LOG2 = 12,
    parameter     INIT_FILE  = ""
) (
    input  logic             aclk,
    input  logic             aresetn,
    axi_sram_slave_if.slave  bus
);
    localparam int         DEPTH       = 1 << DEPTH_LOG2;
    localparam logic [1:0] BURST_FIXED = 2'b00;

    typedef enum logic       {R_IDLE, R_BURST}         r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP}  w_state_t;

    r_state_t              r_state_reg, r_state_next;
    logic                  arready_reg, arready_next;
    logic [3:0]            r_id_reg, r_id_next;
    logic [3:0]            r_len_reg, r_len_next;
    logic [3:0]            r_beat_reg, r_beat_next;
    logic [1:0]            r_burst_reg, r_burst_next;
    logic [DEPTH_LOG2-1:0] r_idx_reg, r_idx_next;
    logic                  ar_fire, r_fire, r_load, rvalid_int;

    w_state_t              w_state_reg, w_state_next;
    logic                  awready_reg, awready_next;
    logic [3:0]            w_id_reg, w_id_next;
    logic [3:0]            w_len_reg, w_len_next;
    logic [3:0]            w_beat_reg, w_beat_next;
    logic [1:0]            w_burst_reg, w_burst_next;
    logic [DEPTH_LOG2-1:0] w_idx_reg, w_idx_next;
    logic                  w_err_reg, w_err_next;
    logic                  aw_fire, w_fire, b_fire;

    wire  [31:0]           rdata_word;
    logic                  unused_inputs;

    assign rvalid_int = (r_state_reg == R_BURST);
    assign ar_fire    = bus.arvalid && arready_reg;
    assign r_fire     = rvalid_int && bus.rready;
    assign r_load     = ar_fire || r_fire;

    assign aw_fire = bus.awvalid && awready_reg;
    assign w_fire  = bus.wvalid && (w_state_reg == W_DATA);
    assign b_fire  = bus.bready && (w_state_reg == W_RESP);

    // ---------------- read channel ----------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state_reg <= R_IDLE;
            arready_reg <= 1'b0;
            r_id_reg    <= '0;
            r_len_reg   <= '0;
            r_beat_reg  <= '0;
            r_burst_reg <= '0;
            r_idx_reg   <= '0;
        end else begin
            r_state_reg <= r_state_next;
            arready_reg <= arready_next;
            r_id_reg    <= r_id_next;
            r_len_reg   <= r_len_next;
            r_beat_reg  <= r_beat_next;
            r_burst_reg <= r_burst_next;
            r_idx_reg   <= r_idx_next;
        end
    end

    always_comb begin
        r_state_next = r_state_reg;
        r_id_next    = r_id_reg;
        r_len_next   = r_len_reg;
        r_beat_next  = r_beat_reg;
        r_burst_next = r_burst_reg;
        r_idx_next   = r_idx_reg;
        case (r_state_reg)
            R_IDLE: begin
                if (ar_fire) begin
                    r_state_next = R_BURST;
                    r_id_next    = bus.arid;
                    r_len_next   = bus.arlen;
                    r_burst_next = bus.arburst;
                    r_idx_next   = bus.araddr[DEPTH_LOG2+1:2];
                    r_beat_next  = '0;
                end
            end
            R_BURST: begin
                if (r_fire) begin
                    r_beat_next = r_beat_reg + 4'd1;
                    // WRAP falls through to the INCR rule; index overflow wraps to 0
                    if (r_burst_reg != BURST_FIXED)
                        r_idx_next = r_idx_reg + 1'b1;
                    if (r_beat_reg == r_len_reg)
                        r_state_next = R_IDLE;
                end
            end
            default: r_state_next = R_IDLE;
        endcase
        arready_next = (r_state_next == R_IDLE);
    end

    assign bus.arready = arready_reg;
    assign bus.rvalid  = rvalid_int;
    assign bus.rid     = r_id_reg;
    assign bus.rresp   = 2'b00;
    assign bus.rlast   = rvalid_int && (r_beat_reg == r_len_reg);
    assign bus.rdata   = rdata_word;

    // ---------------- write channel ----------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state_reg <= W_IDLE;
            awready_reg <= 1'b0;
            w_id_reg    <= '0;
            w_len_reg   <= '0;
            w_beat_reg  <= '0;
            w_burst_reg <= '0;
            w_idx_reg   <= '0;
            w_err_reg   <= 1'b0;
        end else begin
            w_state_reg <= w_state_next;
            awready_reg <= awready_next;
            w_id_reg    <= w_id_next;
            w_len_reg   <= w_len_next;
            w_beat_reg  <= w_beat_next;
            w_burst_reg <= w_burst_next;
            w_idx_reg   <= w_idx_next;
            w_err_reg   <= w_err_next;
        end
    end

    always_comb begin
        w_state_next = w_state_reg;
        w_id_next    = w_id_reg;
        w_len_next   = w_len_reg;
        w_beat_next  = w_beat_reg;
        w_burst_next = w_burst_reg;
        w_idx_next   = w_idx_reg;
        w_err_next   = w_err_reg;
        case (w_state_reg)
            W_IDLE: begin
                if (aw_fire) begin
                    w_state_next = W_DATA;
                    w_id_next    = bus.awid;
                    w_len_next   = bus.awlen;
                    w_burst_next = bus.awburst;
                    w_idx_next   = bus.awaddr[DEPTH_LOG2+1:2];
                    w_beat_next  = '0;
                    w_err_next   = 1'b0;
                end
            end
            W_DATA: begin
                if (w_fire) begin
                    w_beat_next = w_beat_reg + 4'd1;
                    if (w_burst_reg != BURST_FIXED)
                        w_idx_next = w_idx_reg + 1'b1;
                    // Burst length comes from awlen; a misplaced wlast only flags SLVERR
                    if (bus.wlast != (w_beat_reg == w_len_reg))
                        w_err_next = 1'b1;
                    if (w_beat_reg == w_len_reg)
                        w_state_next = W_RESP;
                end
            end
            W_RESP: begin
                if (b_fire)
                    w_state_next = W_IDLE;
            end
            default: w_state_next = W_IDLE;
        endcase
        awready_next = (w_state_next == W_IDLE);
    end

    assign bus.awready = awready_reg;
    assign bus.wready  = (w_state_reg == W_DATA);
    assign bus.bvalid  = (w_state_reg == W_RESP);
    assign bus.bid     = w_id_reg;
    assign bus.bresp   = {w_err_reg, 1'b0};

    // ---------------- storage: one byte-wide RAM per lane ----------------
    // Read port loads at the same edge a write commits, so it sees the old byte.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] lane_rd_reg;

            always_ff @(posedge aclk) begin
                if (w_fire && bus.wstrb[gi])
                    lane_mem[w_idx_reg] <= bus.wdata[gi*8 +: 8];
            end

            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn)
                    lane_rd_reg <= '0;
                else if (r_load)
                    lane_rd_reg <= lane_mem[r_idx_next];
            end

            assign rdata_word[gi*8 +: 8] = lane_rd_reg;
        end
    endgenerate

    assign unused_inputs = ^{bus.araddr[31:DEPTH_LOG2+2], bus.araddr[1:0], bus.arsize,
                             bus.arlock, bus.arcache, bus.arprot,
                             bus.awaddr[31:DEPTH_LOG2+2], bus.awaddr[1:0], bus.awsize,
                             bus.awlock, bus.awcache, bus.awprot, bus.wid,
                             (INIT_FILE != "")};
endmodule

// File: tb/tb_axi_sram_slave.sv
// Randomized bench for axi_sram_slave: AXI master tasks drive bursts and a
// word-array model predicts read data and write responses.
module tb_axi_sram_slave;
    localparam int DEPTH_LOG2 = 12;
    localparam int DEPTH      = 1 << DEPTH_LOG2;
    localparam int TMO        = 50;

    logic aclk;
    logic aresetn;
    int   checks   = 0;
    int   failures = 0;

    logic [31:0] model   [DEPTH];
    logic [31:0] wr_data [16];
    logic [3:0]  wr_strb [16];

    axi_sram_slave_if bus ();

    axi_sram_slave #(.DEPTH_LOG2(DEPTH_LOG2), .INIT_FILE("")) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic int word_idx(input logic [31:0] addr, input logic [1:0] burst, input int beat);
        int base;
        base = int'(addr >> 2) % DEPTH;
        return (burst == 2'b00) ? base : (base + beat) % DEPTH;
    endfunction

    task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                             input logic [1:0] burst, input int wlast_pos);
        int n;
        int idx;
        logic [1:0] exp_resp;
        bus.awid = id; bus.awaddr = addr; bus.awlen = 4'(len); bus.awburst = burst;
        bus.awsize = 3'd2; bus.awvalid = 1'b1;
        n = 0;
        while (bus.awready !== 1'b1 && n < TMO) begin @(posedge aclk); #1; n++; end
        checks++;
        if (n >= TMO) begin failures++; $display("FAIL wr_aw_timeout awready=%b required=1", bus.awready); end
        @(posedge aclk); #1;
        bus.awvalid = 1'b0;
        checks++;
        if (bus.wready !== 1'b1) begin
            failures++; $display("FAIL wr_latency wready=%b required=1 at T+1", bus.wready);
        end
        for (int i = 0; i <= len; i++) begin
            bus.wvalid = 1'b1; bus.wdata = wr_data[i]; bus.wstrb = wr_strb[i];
            bus.wlast = (i == wlast_pos); bus.wid = id;
            n = 0;
            while (bus.wready !== 1'b1 && n < TMO) begin @(posedge aclk); #1; n++; end
            if (n >= TMO) begin
                checks++; failures++; $display("FAIL wr_w_timeout beat=%0d wready=%b required=1", i, bus.wready);
            end
            @(posedge aclk); #1;
            idx = word_idx(addr, burst, i);
            for (int b = 0; b < 4; b++)
                if (wr_strb[i][b]) model[idx][b*8 +: 8] = wr_data[i][b*8 +: 8];
        end
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
        exp_resp = (wlast_pos == len) ? 2'b00 : 2'b10;
        checks++;
        if (bus.bvalid !== 1'b1 || bus.bid !== id || bus.bresp !== exp_resp) begin
            failures++;
            $display("FAIL wr_bresp bvalid=%b bid=%h bresp=%b required bvalid=1 bid=%h bresp=%b",
                     bus.bvalid, bus.bid, bus.bresp, id, exp_resp);
        end
        bus.bready = 1'b1;
        @(posedge aclk); #1;
        bus.bready = 1'b0;
        checks++;
        if (bus.awready !== 1'b1 || bus.bvalid !== 1'b0) begin
            failures++;
            $display("FAIL wr_done awready=%b bvalid=%b required awready=1 bvalid=0", bus.awready, bus.bvalid);
        end
        $display("WR id=%h addr=%h len=%0d burst=%b wlast_pos=%0d bresp=%b", id, addr, len, burst, wlast_pos, exp_resp);
    endtask

    task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input logic [1:0] burst, input bit stalls);
        int n;
        int idx;
        logic [31:0] held;
        bus.arid = id; bus.araddr = addr; bus.arlen = 4'(len); bus.arburst = burst;
        bus.arsize = 3'd2; bus.arvalid = 1'b1;
        n = 0;
        while (bus.arready !== 1'b1 && n < TMO) begin @(posedge aclk); #1; n++; end
        checks++;
        if (n >= TMO) begin failures++; $display("FAIL rd_ar_timeout arready=%b required=1", bus.arready); end
        @(posedge aclk); #1;
        bus.arvalid = 1'b0;
        checks++;
        if (bus.rvalid !== 1'b1) begin
            failures++; $display("FAIL rd_latency rvalid=%b required=1 at T+1", bus.rvalid);
        end
        for (int i = 0; i <= len; i++) begin
            idx = word_idx(addr, burst, i);
            if (stalls) begin
                for (int k = 0; k < 3 && $urandom_range(0, 1) == 0; k++) begin
                    bus.rready = 1'b0;
                    held = bus.rdata;
                    @(posedge aclk); #1;
                    checks++;
                    if (bus.rvalid !== 1'b1 || bus.rdata !== held) begin
                        failures++;
                        $display("FAIL rd_hold beat=%0d rvalid=%b rdata=%h required rvalid=1 rdata=%h",
                                 i, bus.rvalid, bus.rdata, held);
                    end
                end
            end
            bus.rready = 1'b1;
            checks++;
            if (bus.rvalid !== 1'b1 || bus.rdata !== model[idx] || bus.rid !== id ||
                bus.rlast !== (i == len) || bus.rresp !== 2'b00) begin
                failures++;
                $display("FAIL rd_beat beat=%0d rvalid=%b rdata=%h rid=%h rlast=%b rresp=%b required rvalid=1 rdata=%h rid=%h rlast=%b rresp=00",
                         i, bus.rvalid, bus.rdata, bus.rid, bus.rlast, bus.rresp, model[idx], id, (i == len));
            end
            @(posedge aclk); #1;
        end
        bus.rready = 1'b0;
        checks++;
        if (bus.arready !== 1'b1 || bus.rvalid !== 1'b0) begin
            failures++;
            $display("FAIL rd_done arready=%b rvalid=%b required arready=1 rvalid=0", bus.arready, bus.rvalid);
        end
        $display("RD id=%h addr=%h len=%0d burst=%b stalls=%0d", id, addr, len, burst, stalls);
    endtask

    task automatic fill_full(input int len);
        for (int i = 0; i <= len; i++) begin
            wr_data[i] = $urandom;
            wr_strb[i] = 4'hF;
        end
    endtask

    task automatic test_reset;
        bus.arvalid = 0; bus.rready = 0; bus.awvalid = 0; bus.wvalid = 0; bus.bready = 0;
        bus.arid = 0; bus.araddr = 0; bus.arlen = 0; bus.arsize = 0; bus.arburst = 0;
        bus.arlock = 0; bus.arcache = 0; bus.arprot = 0;
        bus.awid = 0; bus.awaddr = 0; bus.awlen = 0; bus.awsize = 0; bus.awburst = 0;
        bus.awlock = 0; bus.awcache = 0; bus.awprot = 0;
        bus.wid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0;
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        checks++;
        if ({bus.arready, bus.awready, bus.wready, bus.rvalid, bus.bvalid} !== 5'b0) begin
            failures++;
            $display("FAIL reset_handshake ar/aw/w/rv/bv=%b required=00000",
                     {bus.arready, bus.awready, bus.wready, bus.rvalid, bus.bvalid});
        end
        checks++;
        if ({bus.rlast, bus.rresp, bus.bresp, bus.rid, bus.bid, bus.rdata} !== 45'b0) begin
            failures++;
            $display("FAIL reset_payload rlast=%b rresp=%b bresp=%b rid=%h bid=%h rdata=%h required all zero",
                     bus.rlast, bus.rresp, bus.bresp, bus.rid, bus.bid, bus.rdata);
        end
        aresetn = 1'b1;
        checks++;
        if (bus.arready !== 1'b0) begin
            failures++; $display("FAIL reset_release_early arready=%b required=0", bus.arready);
        end
        @(posedge aclk); #1;
        checks++;
        if (bus.arready !== 1'b1 || bus.awready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release arready=%b awready=%b required=1 1", bus.arready, bus.awready);
        end
    endtask

    task automatic test_single_read;
        wr_data[0] = 32'hDEADBEEF; wr_strb[0] = 4'hF;
        axi_write(4'h1, 32'h100, 0, 2'b01, 0);
        axi_read(4'h2, 32'h100, 0, 2'b01, 1'b0);
    endtask

    task automatic test_burst;
        for (int i = 0; i < 8; i++) begin wr_data[i] = 32'(i + 1); wr_strb[i] = 4'hF; end
        axi_write(4'h3, 32'h200, 7, 2'b01, 7);
        axi_read(4'h4, 32'h200, 7, 2'b01, 1'b0);
        axi_read(4'h5, 32'h200, 7, 2'b01, 1'b1);
    endtask

    task automatic test_strobes;
        wr_data[0] = 32'h11223344; wr_strb[0] = 4'hF;
        axi_write(4'h6, 32'h300, 0, 2'b01, 0);
        wr_data[0] = 32'hAABBCCDD; wr_strb[0] = 4'b0101;
        axi_write(4'h6, 32'h300, 0, 2'b01, 0);
        axi_read(4'h7, 32'h300, 0, 2'b01, 1'b0);
    endtask

    task automatic test_wlast_error;
        fill_full(3);
        axi_write(4'(($urandom_range(0, 15))), 32'h400, 3, 2'b01, 1);
        axi_read(4'h8, 32'h400, 3, 2'b01, 1'b0);
        fill_full(2);
        axi_write(4'h9, 32'h440, 2, 2'b01, -1);
    endtask

    task automatic test_fixed_and_wrap;
        for (int i = 0; i < 4; i++) begin wr_data[i] = 32'(i + 1); wr_strb[i] = 4'hF; end
        axi_write(4'hA, 32'h80, 3, 2'b00, 3);
        axi_read(4'hB, 32'h80, 0, 2'b01, 1'b0);
        axi_read(4'hB, 32'h80, 2, 2'b00, 1'b0);
        fill_full(0);
        axi_write(4'hC, 32'((DEPTH - 1) * 4), 0, 2'b01, 0);
        fill_full(0);
        axi_write(4'hC, 32'(DEPTH * 4), 0, 2'b01, 0);
        axi_read(4'hD, 32'((DEPTH - 1) * 4), 1, 2'b01, 1'b0);
    endtask

    task automatic test_early_w;
        bus.wvalid = 1'b1; bus.wdata = 32'hFFFF_FFFF; bus.wstrb = 4'hF; bus.wlast = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge aclk); #1;
            checks++;
            if (bus.wready !== 1'b0) begin
                failures++; $display("FAIL early_w cycle=%0d wready=%b required=0", i, bus.wready);
            end
        end
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
        axi_read(4'h1, 32'h100, 0, 2'b01, 1'b0);
    endtask

    task automatic test_random;
        logic [1:0]  burst;
        logic [31:0] addr;
        int          len;
        for (int t = 0; t < 8; t++) begin
            len   = $urandom_range(0, 7);
            burst = 2'($urandom_range(0, 2));
            addr  = 32'h1000 + 32'($urandom_range(0, 63) * 4);
            for (int i = 0; i <= len; i++) begin
                wr_data[i] = $urandom;
                wr_strb[i] = 4'($urandom_range(0, 15));
            end
            axi_write(4'($urandom_range(0, 15)), addr, len, burst, len);
            axi_read(4'($urandom_range(0, 15)), addr, len, burst, 1'b1);
        end
    endtask

    task automatic test_back_to_back;
        fill_full(7);
        fork
            axi_read(4'h2, 32'h200, 7, 2'b01, 1'b1);
            axi_write(4'h3, 32'h600, 7, 2'b01, 7);
        join
        axi_read(4'h4, 32'h600, 7, 2'b01, 1'b0);
    endtask

    task automatic test_reset_mid;
        int n;
        bus.arid = 4'h5; bus.araddr = 32'h200; bus.arlen = 4'd7; bus.arburst = 2'b01; bus.arvalid = 1'b1;
        n = 0;
        while (bus.arready !== 1'b1 && n < TMO) begin @(posedge aclk); #1; n++; end
        @(posedge aclk); #1;
        bus.arvalid = 1'b0; bus.rready = 1'b1;
        repeat (3) @(posedge aclk);
        #3;
        aresetn = 1'b0;
        #1;
        checks++;
        if (bus.rvalid !== 1'b0 || bus.arready !== 1'b0 || bus.rdata !== 32'h0 || bus.rlast !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_async rvalid=%b arready=%b rdata=%h rlast=%b required 0 0 00000000 0",
                     bus.rvalid, bus.arready, bus.rdata, bus.rlast);
        end
        bus.rready = 1'b0;
        @(posedge aclk); #1;
        checks++;
        if (bus.rvalid !== 1'b0 || bus.arready !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_hold rvalid=%b arready=%b required 0 0", bus.rvalid, bus.arready);
        end
        aresetn = 1'b1;
        @(posedge aclk); #1;
        checks++;
        if (bus.arready !== 1'b1 || bus.rvalid !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_release arready=%b rvalid=%b required 1 0", bus.arready, bus.rvalid);
        end
        axi_read(4'h6, 32'h200, 7, 2'b01, 1'b0);
        axi_read(4'h7, 32'h600, 7, 2'b01, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
        test_reset;
        test_single_read;
        test_burst;
        test_strobes;
        test_wlast_error;
        test_fixed_and_wrap;
        test_early_w;
        test_random;
        test_back_to_back;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
